processor_param: RTL
====================

# processor_param

Parametrised successor to the 8-bit, 8-register multi-cycle processor. It executes one instruction per `start` request through a multi-cycle FSM. Data width and register count are configurable. Compared with its predecessor it adds logic and shift operations, carry/zero flags, a `data_enable`-gated LOAD, illegal-opcode reporting and a `busy` indicator. It sits under the same instruction-driving testbench and exposes the register file for checking.

## Interface
- `DATA_WIDTH`, 8: register/ALU width; must be ≥ 4.
- `NUM_REGS`, 8: register count; power of two, ≥ 2.
- `REG_AW`, `$clog2(NUM_REGS)`: derived; not overridden.
- `INSTR_W`, `4 + 3*REG_AW`: derived; 13 at defaults.

Ports:
- `clock`  in  1  single clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `machine_code`  in  INSTR_W  `{op[3:0], rd, rs1, rs2}`; captured at start.
- `dataIN`  in  DATA_WIDTH  LOAD data.
- `data_enable`  in  1  marks `dataIN` valid for LOAD.
- `done`  out  1  one-cycle completion pulse.
- `busy`  out  1  high whenever state ≠ IDLE.
- `illegal`  out  1  high with `done` for an undefined opcode.
- `flags`  out  2  `{C, Z}`.
- `disp_out`  out  DATA_WIDTH  last DISP value.
- `BUS_global`  out  DATA_WIDTH  write-back value in WRITEBACK, else 0.
- `reg_test`  out  NUM_REGS*DATA_WIDTH  register i at `[i*DATA_WIDTH +: DATA_WIDTH]`.

## Operation
- Opcodes:
  - 0 DISP: `disp_out`←rs1.
  - 1 LOAD: rd←`dataIN`.
  - 2 MOVE: rd←rs1.
  - 3 ADD: rd←rs1+rs2.
  - 4 SUB: rd←rs1−rs2.
  - 5 ADDI: rd←rs1+zext(rs2 field).
  - 6 AND, 7 OR, 8 XOR: rd←rs1 op rs2.
  - 9 SHL / 10 SHR: rd←rs1 shifted (logical) by the rs2 field value; a shift ≥ DATA_WIDTH gives 0.
  - 11–15: illegal.
- FSM states: IDLE, DECODE, READ, EXEC, WAIT_DATA, WRITEBACK.
- Paths:
  - ALU ops and MOVE: IDLE→DECODE→READ→EXEC→WRITEBACK→IDLE.
  - DISP: DECODE→READ→WRITEBACK.
  - LOAD: DECODE→WAIT_DATA, held until `data_enable`=1, then WRITEBACK.
  - Illegal: DECODE→WRITEBACK with no writes.
- DECODE latches the instruction. READ latches operands A/B. EXEC latches result and next flags. WRITEBACK writes rd, updates flags, drives `done`.
- Arithmetic is modulo 2^DATA_WIDTH.
  - C: carry-out for ADD/ADDI; borrow (rs1 < rs2) for SUB; last bit shifted out for shifts (0 when the shift is 0); 0 for logic ops.
  - Z: result == 0.
- Flags change only on opcodes 3–10. LOAD, MOVE, DISP and illegal leave them unchanged.
- rd == rs1 == rs2 is legal, because operands are latched before the write.
- `start` outside IDLE is ignored and is not queued.

## Timing
- Reset (async assert, sync-safe deassert):
  - state IDLE.
  - All registers 0.
  - `flags`, `disp_out`, `done`, `busy`, `illegal`, `BUS_global` all 0.
- Reset asserted mid-instruction aborts it: no register, flag or `disp_out` write, and no `done`.
- Latency, counted from the edge that samples `start`=1 to the cycle `done`=1:
  - ALU/MOVE: 4 cycles.
  - DISP: 3 cycles.
  - Illegal: 2 cycles.
  - LOAD: 3 cycles when `data_enable` is high in the first WAIT_DATA cycle; otherwise 1 cycle after the edge that samples `data_enable`=1.
- `done`/`illegal` are high for exactly one cycle. Register and flag updates are visible on `reg_test`/`flags` in the cycle after `done`.
- `busy` rises the cycle after start is sampled and falls together with the return to IDLE. `start` may be re-asserted in the cycle after `done`.

## Structure
- Package `processor_pkg`:
  - `opcode_t` (4-bit enum).
  - `state_t`.
  - Flag index constants `FLAG_Z=0`, `FLAG_C=1`.
- Sub-module `alu_param`: combinational, parameter DATA_WIDTH, inputs op/A/B/shamt, outputs result, C, Z.
- The register file and FSM live in `processor_param`.

## Test plan
- Reset, then LOAD r1 with `dataIN`=8'h21 and `data_enable` held high → `done` 3 cycles after start; `reg_test[15:8]`=8'h21; flags 0.
- LOAD r2 with `dataIN`=8'h01, `data_enable` raised 5 cycles late, and a second `start` pulsed while busy → `busy` stays high; `done` arrives 1 cycle after `data_enable` is sampled; the extra `start` is ignored; r2=8'h01.
- ADD r1,r1,r2 → r1=8'h22, {C,Z}=00, `done` at 4 cycles; then SUB r1,r1,r2 → r1=8'h21.
- r3=8'hFF, ADDI r3,r3,1 → r3=8'h00, {C,Z}=11. With r4=0, SUB r4,r4,r2 → 8'hFF, C=1, Z=0.
- Shift, display and illegal opcode:
  - r5=8'h81, SHL r5,r5,1 → 8'h02, C=1.
  - DISP r1 → `disp_out`=8'h21, registers unchanged.
  - Opcode 4'hF → `done` and `illegal` high for one cycle; no state change.
- Reset mid-operation and a second parameter set:
  - Reset pulsed during EXEC of an ADD → all registers 0; no `done`.
  - DATA_WIDTH=16, NUM_REGS=16: 16'hFFFF+16'h0001 → 16'h0000, {C,Z}=11.

Source files
------------

// File: rtl/processor_pkg.sv
// Shared types for the parametrised multi-cycle processor.
// Opcodes, FSM states and flag bit positions.
package processor_pkg;

  typedef enum logic [3:0] {
    OP_DISP = 4'd0,
    OP_LOAD = 4'd1,
    OP_MOVE = 4'd2,
    OP_ADD  = 4'd3,
    OP_SUB  = 4'd4,
    OP_ADDI = 4'd5,
    OP_AND  = 4'd6,
    OP_OR   = 4'd7,
    OP_XOR  = 4'd8,
    OP_SHL  = 4'd9,
    OP_SHR  = 4'd10
  } opcode_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_READ,
    S_EXEC,
    S_WAIT_DATA,
    S_WRITEBACK
  } state_t;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;

  function automatic logic op_legal(
    input logic [3:0] op
  );
    return op <= 4'd10;
  endfunction

  function automatic logic op_sets_flags(
    input logic [3:0] op
  );
    return (op >= 4'd3) && (op <= 4'd10);
  endfunction

endpackage

// File: rtl/processor_param_alu.sv
// Combinational ALU: add/sub/addi, logic ops and logical shifts.
// Carry is the adder carry, the subtract borrow or the last bit shifted out.
module alu_param
  import processor_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int SHAMT_W    = 3
) (
  input  logic [3:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [SHAMT_W-1:0]    shamt,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  c,
  output logic                  z
);

  localparam int W = DATA_WIDTH;

  logic [W:0]   wide;
  logic [W-1:0] imm;

  // One extra bit on every path catches carry, borrow or shifted-out bit
  always_comb begin
    imm    = W'(shamt);
    wide   = '0;
    result = a;
    c      = 1'b0;
    case (op)
      OP_ADD: begin
        wide   = {1'b0, a} + {1'b0, b};
        result = wide[W-1:0];
        c      = wide[W];
      end
      OP_SUB: begin
        wide   = {1'b0, a} - {1'b0, b};
        result = wide[W-1:0];
        c      = wide[W];
      end
      OP_ADDI: begin
        wide   = {1'b0, a} + {1'b0, imm};
        result = wide[W-1:0];
        c      = wide[W];
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_SHL: begin
        wide   = {1'b0, a} << shamt;
        result = wide[W-1:0];
        c      = wide[W];
      end
      OP_SHR: begin
        wide   = {a, 1'b0} >> shamt;
        result = wide[W:1];
        c      = wide[0];
      end
      default: result = a;
    endcase
    z = (result == '0);
  end

endmodule

// File: rtl/processor_param.sv
// Multi-cycle processor: instruction latch, register file and FSM.
// One instruction per start; results commit only in WRITEBACK.
module processor_param
  import processor_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS   = 8,
  parameter int REG_AW     = $clog2(NUM_REGS),
  parameter int INSTR_W    = 4 + 3 * REG_AW
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  input  logic [INSTR_W-1:0]             machine_code,
  input  logic [DATA_WIDTH-1:0]          dataIN,
  input  logic                           data_enable,
  output logic                           done,
  output logic                           busy,
  output logic                           illegal,
  output logic [1:0]                     flags,
  output logic [DATA_WIDTH-1:0]          disp_out,
  output logic [DATA_WIDTH-1:0]          BUS_global,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_test
);

  state_t state;
  state_t state_nx;

  logic [INSTR_W-1:0]    instr;
  logic [3:0]            op;
  logic [REG_AW-1:0]     rd;
  logic [REG_AW-1:0]     rs1;
  logic [REG_AW-1:0]     rs2;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [DATA_WIDTH-1:0] opa;
  logic [DATA_WIDTH-1:0] opb;
  logic [DATA_WIDTH-1:0] res;
  logic [1:0]            cz;

  logic [DATA_WIDTH-1:0] alu_res;
  logic                  alu_c;
  logic                  alu_z;

  logic                  legal;
  logic                  writes_rd;
  logic [DATA_WIDTH-1:0] wb_val;

  assign op  = instr[INSTR_W-1 -: 4];
  assign rd  = instr[3*REG_AW-1 -: REG_AW];
  assign rs1 = instr[2*REG_AW-1 -: REG_AW];
  assign rs2 = instr[REG_AW-1:0];

  assign legal     = op_legal(op);
  assign writes_rd = legal && (op != OP_DISP);

  alu_param #(
    .DATA_WIDTH (DATA_WIDTH),
    .SHAMT_W    (REG_AW)
  ) u_alu (
    .op     (op),
    .a      (opa),
    .b      (opb),
    .shamt  (rs2),
    .result (alu_res),
    .c      (alu_c),
    .z      (alu_z)
  );

  // Value committed in WRITEBACK: DISP shows rs1, others the latched result
  always_comb begin
    wb_val = '0;
    if (legal) begin
      wb_val = (op == OP_DISP) ? opa : res;
    end
  end

  // FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and status outputs
  always_comb begin
    state_nx   = state;
    done       = 1'b0;
    illegal    = 1'b0;
    busy       = (state != S_IDLE);
    BUS_global = '0;
    unique case (state)
      S_IDLE: begin
        if (start) state_nx = S_DECODE;
      end
      S_DECODE: begin
        unique case (1'b1)
          !legal:          state_nx = S_WRITEBACK;
          (op == OP_LOAD): state_nx = S_WAIT_DATA;
          default:         state_nx = S_READ;
        endcase
      end
      S_READ: begin
        state_nx = (op == OP_DISP) ? S_WRITEBACK : S_EXEC;
      end
      S_EXEC: begin
        state_nx = S_WRITEBACK;
      end
      S_WAIT_DATA: begin
        if (data_enable) state_nx = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        state_nx   = S_IDLE;
        done       = 1'b1;
        illegal    = !legal;
        BUS_global = wb_val;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Datapath latches: instruction, operands, result, pending flags
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      instr    <= '0;
      opa      <= '0;
      opb      <= '0;
      res      <= '0;
      cz       <= '0;
      flags    <= '0;
      disp_out <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) instr <= machine_code;
        end
        S_READ: begin
          opa <= regs[rs1];
          opb <= regs[rs2];
        end
        S_EXEC: begin
          res        <= alu_res;
          cz[FLAG_C] <= alu_c;
          cz[FLAG_Z] <= alu_z;
        end
        S_WAIT_DATA: begin
          if (data_enable) res <= dataIN;
        end
        S_WRITEBACK: begin
          if (op_sets_flags(op)) flags <= cz;
          if (op == OP_DISP) disp_out <= opa;
        end
        default: ;
      endcase
    end
  end

  // Register file write port
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (state == S_WRITEBACK && writes_rd) begin
      regs[rd] <= wb_val;
    end
  end

  // Flatten register file for observation
  always_comb begin
    reg_test = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_test[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
    end
  end

endmodule
